// File: rtl/pwm_wave_pkg.sv
// Shared constants for the PWM waveform sample generator: mode encodings and
// the 16-entry, 8-bit sine table that is scaled down to the threshold width.
package pwm_wave_pkg;

    localparam logic [1:0] MODE_RAMP   = 2'd0;
    localparam logic [1:0] MODE_TRI    = 2'd1;
    localparam logic [1:0] MODE_SQUARE = 2'd2;
    localparam logic [1:0] MODE_SINE   = 2'd3;

    // round(127.5 * (1 + sin(2*pi*k/16)))
    localparam logic [7:0] SINE_LUT [16] = '{
        8'd128, 8'd176, 8'd218, 8'd245, 8'd255, 8'd245, 8'd218, 8'd176,
        8'd128, 8'd79,  8'd37,  8'd10,  8'd0,   8'd10,  8'd37,  8'd79
    };

endpackage

// File: rtl/pwm_wave_gen_period_counter.sv
// Mirror of the PWM period counter plus the periods-per-sample hold counter;
// flags the last cycle of each PWM period and which of those take a new sample.
module pwm_period_counter
    import pwm_wave_pkg::*;
#(
    parameter int NBITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       periods,
    output logic             boundary,
    output logic             update,
    output logic             period_start
);

    logic [NBITS-1:0] cnt;
    logic [7:0]       hold;
    logic [7:0]       hold_last;

    // periods == 0 is treated as 1; comparing with >= lets a shrinking
    // periods value trigger an update at the very next boundary
    assign hold_last    = (periods == 8'd0) ? 8'd0 : periods - 8'd1;
    assign boundary     = (cnt == {NBITS{1'b1}});
    assign update       = boundary && (hold >= hold_last);
    assign period_start = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            hold <= 8'd0;
        end else begin
            cnt <= cnt + 1'b1;
            if (update) begin
                hold <= 8'd0;
            end else if (boundary) begin
                hold <= hold + 8'd1;
            end
        end
    end

endmodule

// File: rtl/pwm_wave_gen.sv
// Waveform sample generator feeding the PWM threshold; a new sample is taken
// only at period boundaries so each PWM period carries one duty value.
module pwm_wave_gen
    import pwm_wave_pkg::*;
#(
    parameter int NBITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [7:0]       periods,
    output logic [NBITS-1:0] threshold,
    output logic             sample_tick,
    output logic             period_start
);

    localparam int PW = NBITS + 1;
    localparam logic [PW-1:0] MAX_P = PW'((1 << NBITS) - 1);

    logic          boundary;
    logic          update;
    logic          take_sample;
    logic [PW-1:0] phase;
    logic [1:0]    mode_q;

    function automatic logic [NBITS-1:0] sample_f(input logic [1:0] m,
                                                   input logic [PW-1:0] p);
        logic [NBITS-1:0] res;
        logic [PW-1:0]    tri_v;
        logic [7:0]       sin_v;
        tri_v = (p <= MAX_P) ? p : ((MAX_P << 1) - p);
        sin_v = 8'(SINE_LUT[p[3:0]] >> (8 - NBITS));
        res   = '0;
        case (m)
            MODE_RAMP:   res = p[NBITS-1:0];
            MODE_TRI:    res = tri_v[NBITS-1:0];
            MODE_SQUARE: res = p[NBITS-1] ? {NBITS{1'b1}} : {NBITS{1'b0}};
            default:     res = sin_v[NBITS-1:0];
        endcase
        return res;
    endfunction

    // Last phase index before wrap, i.e. L-1 for each mode
    function automatic logic [PW-1:0] last_phase(input logic [1:0] m);
        logic [PW-1:0] res;
        case (m)
            MODE_TRI:  res = (MAX_P << 1) - 1'b1;
            MODE_SINE: res = PW'(15);
            default:   res = MAX_P;
        endcase
        return res;
    endfunction

    pwm_period_counter #(
        .NBITS(NBITS)
    ) u_cnt (
        .clk          (clk),
        .rst          (rst),
        .periods      (periods),
        .boundary     (boundary),
        .update       (update),
        .period_start (period_start)
    );

    assign take_sample = boundary && update && en;

    // Sample register stage: threshold becomes visible with cnt == 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            threshold   <= '0;
            sample_tick <= 1'b0;
            phase       <= '0;
            mode_q      <= MODE_RAMP;
        end else begin
            sample_tick <= 1'b0;
            if (take_sample) begin
                sample_tick <= 1'b1;
                if (mode != mode_q) begin
                    mode_q    <= mode;
                    threshold <= sample_f(mode, '0);
                    phase     <= PW'(1);
                end else begin
                    threshold <= sample_f(mode_q, phase);
                    phase     <= (phase >= last_phase(mode_q)) ? '0 : phase + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/pwm_wave_gen.md
# pwm_wave_gen

Waveform sample generator that sits directly upstream of the PWM generator and drives its `threshold` input. It produces ramp, triangle, square or sine sample sequences and changes the threshold only at PWM period boundaries, so every PWM period uses exactly one duty-cycle value. Together with the PWM generator and the external RC low-pass filter, it forms the PWM DAC.

## Interface
- `NBITS`, default 4: threshold width; must equal the PWM `THRESHOLD_NBITS`; legal range 4..8.
- `clk` input, 1 bit: PWM clock, 100 MHz, the same clock as the PWM block.
- `rst` input, 1 bit: asynchronous, active-high reset; must be the same reset net as the PWM block.
- `en` input, 1 bit: when 1, sample updates occur; when 0, `threshold` holds its value.
- `mode` input, 2 bits: 0 = ramp, 1 = triangle, 2 = square, 3 = sine.
- `periods` input, 8 bits: number of PWM periods per sample; a value of 0 is treated as 1.
- `threshold` output, NBITS bits: duty value to the PWM generator.
- `sample_tick` output, 1 bit: one-cycle pulse, registered, high in the first cycle a new `threshold` is visible.
- `period_start` output, 1 bit: one-cycle pulse, high while the mirror counter equals 0.

## Operation
- **Reset values**
  - Mirror counter `cnt` = 0; hold counter = 0; phase = 0; `mode_q` = 0.
  - `threshold` = 0; `sample_tick` = 0.
  - `period_start` = 1, since `cnt` = 0.
- **Mirror counter**
  - NBITS-bit, free-running from reset; it runs independently of `en`.
  - Wraps from 2^NBITS−1 to 0, which keeps it cycle-aligned with the PWM counter.
- **Boundary** is the cycle where `cnt` = 2^NBITS−1.
  - At each boundary the hold counter increments.
  - When the hold counter reaches max(`periods`,1)−1, the boundary is an **update boundary**; the hold counter clears there.
  - `periods` is sampled only at boundaries.
- **At an update boundary with `en` = 1:**
  - If `mode` ≠ `mode_q`: `mode_q` ← `mode`, `threshold` ← f(`mode`, 0), phase ← 1.
  - Otherwise: `threshold` ← f(`mode_q`, phase), and phase advances modulo the mode length L.
  - `sample_tick` ← 1.
- **At an update boundary with `en` = 0:** no change to `threshold`, phase or `mode_q`; `sample_tick` stays 0; the hold counter still cycles.
- **Sample functions** (MAX = 2^NBITS−1; phase width NBITS+1):
  - Ramp: f = p; L = 2^NBITS.
  - Triangle: f = p for p ≤ MAX, else 2·MAX−p; L = 2·MAX. For NBITS=4 this gives 0..15..1, a 30-sample period.
  - Square: f = MAX if p[NBITS−1] = 1, else 0; L = 2^NBITS.
  - Sine: L = 16; f = SINE_LUT[p] >> (8−NBITS), where SINE_LUT is 8-bit round(127.5·(1+sin(2πk/16))).
    - Table values: 128,176,218,245,255,245,218,176,128,79,37,10,0,10,37,79.
    - For NBITS=4: 8,11,13,15,15,15,13,11,8,4,2,0,0,0,2,4.
- **Reset mid-operation** returns every register to its reset value immediately, with no update at the pending boundary.

## Timing
- `threshold` is registered and changes on the clock edge that ends the boundary cycle. The new value is therefore valid from `cnt` = 0 through the whole following PWM period.
- Latency from an update-boundary edge to `threshold` valid: 0 cycles. `sample_tick` is coincident with `period_start` in that cycle.
- With NBITS=4 and `periods`=P, samples are spaced 16·P clocks apart; one sample per 160 ns when P=1.
- After reset release, the first boundary is the 16th rising edge (NBITS=4).
- An `en` or `mode` change between boundaries has no effect until the next update boundary.
- A change of `periods` takes effect at the next boundary, compared against the current hold count. If the new value is ≤ the hold count, that boundary is an update boundary.

## Structure
- Package `pwm_wave_pkg`: mode constants (MODE_RAMP, MODE_TRI, MODE_SQUARE, MODE_SINE) and the 16×8 SINE_LUT constant.
- Sub-module `pwm_period_counter`: the NBITS mirror counter plus the hold counter; outputs `boundary`, `update` and `period_start`.
- Top level: phase register, mode register, f() selection and output registers.

## Test plan
- **Reset and alignment.** Assert `rst`, release; NBITS=4, `en`=1, `mode`=0, `periods`=1.
  - Required: `threshold`=0 and `period_start`=1 right after reset.
  - First `sample_tick` at the 16th edge; `threshold` sequence 0,1,2…15,0 with one step per 16 clocks.
- **Triangle.** `mode`=1, `periods`=1, starting from ramp mid-sequence.
  - Required: next sample 0, then 1..15,14..1,0, repeating with a period of 30 samples.
- **Sine and hold.** `mode`=3, `periods`=2.
  - Required: 8,11,13,15,15,15,13,11,8,4,2,0,0,0,2,4; each value held 32 clocks.
- **Enable gating.** Deassert `en` mid-ramp at `threshold`=5 for 3 boundaries, then reassert.
  - Required: `threshold` stays 5 and `sample_tick` stays 0 while `en`=0; next sample is 6.
- **Edge values.** `periods`=0 behaves identically to `periods`=1. Square mode gives eight 0s then eight 15s.
- **Reset mid-operation.** Pulse `rst` asynchronously at `cnt`=7 with `threshold`=9.
  - Required: immediate `threshold`=0 and `cnt`=0; sequence restarts as in the first scenario.
